// File: rtl/fishing_game_ctrl.sv
// -----------------------------------------------------------------------------
// fishing_game_ctrl
//
// Game-state controller for a single-player fishing game. A fish swims
// leftwards along a lane whose depth depends on the current level. The player
// steers a rod horizontally while the line drops towards the lane. Pressing
// "up" with the rod and line inside the level's catch window hooks the fish.
// The player then reels it to the surface before it escapes. Landing a fish
// scores level+1 and advances the level. Landing the last level wins the game,
// and running out of time loses it.
//
// All state advances only on cycles where the frame enable `tick` is high.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   tick       in   one-cycle frame enable
//   up         in   hook button (level-sensitive)
//   left/right in   rod steering / restart buttons (level-sensitive)
//   reel       in   reel velocity, nonzero means reeling
//   rod_x      out  rod x position
//   line_y     out  line tip y position
//   fish_x     out  fish x position
//   fish_y     out  fish y position
//   level      out  current level index
//   state      out  FISH=0, CATCH=1, WIN=2, LOSE=3
//   score      out  current score
//   hiscore    out  best final score since reset
//   time_left  out  remaining FISH ticks for this level
//   win/lose   out  asserted while in WIN / LOSE
// -----------------------------------------------------------------------------
module fishing_game_ctrl #(
  parameter int NUM_LEVELS   = 4,
  parameter int LANE0_Y      = 470,
  parameter int LANE_STEP    = 90,
  parameter int SURFACE_Y    = 106,
  parameter int FISH_SPEED   = 2,
  parameter int ROD_SPEED    = 3,
  parameter int LINE_DROP    = 4,
  parameter int REEL_STEP    = 2,
  parameter int BASE_W       = 16,
  parameter int BASE_H       = 10,
  parameter int TIME_LIMIT   = 600,
  parameter int ESCAPE_TICKS = 32,
  parameter int X_MIN        = 144,
  parameter int X_MAX        = 798,
  parameter int ROD_X_MIN    = 312
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        up,
  input  logic        left,
  input  logic        right,
  input  logic [8:0]  reel,
  output logic [9:0]  rod_x,
  output logic [9:0]  line_y,
  output logic [9:0]  fish_x,
  output logic [9:0]  fish_y,
  output logic [2:0]  level,
  output logic [1:0]  state,
  output logic [15:0] score,
  output logic [15:0] hiscore,
  output logic [15:0] time_left,
  output logic        win,
  output logic        lose
);

  typedef enum logic [1:0] {
    ST_FISH  = 2'd0,
    ST_CATCH = 2'd1,
    ST_WIN   = 2'd2,
    ST_LOSE  = 2'd3
  } state_t;

  localparam int ROD_X_RST  = 450;
  localparam int LINE_Y_RST = 155;

  // Lane depth for a level, clamped at zero so a large level can never wrap.
  function automatic logic [9:0] lane_of(input logic [2:0] l);
    int v;
    v = LANE0_Y - int'(l) * LANE_STEP;
    if (v < 0) v = 0;
    return 10'(v);
  endfunction

  // Catch window shrinks by half per level but never below one pixel.
  function automatic int win_w(input logic [2:0] l);
    int v;
    v = BASE_W >> l;
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int win_h(input logic [2:0] l);
    int v;
    v = BASE_H >> l;
    return (v < 1) ? 1 : v;
  endfunction

  // Saturating subtract on a 10-bit position.
  function automatic logic [9:0] sub_sat(input logic [9:0] a, input int d);
    return (int'(a) < d) ? 10'd0 : 10'(int'(a) - d);
  endfunction

  function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t      st_q, st_d;
  logic [9:0]  rod_d, line_d, fx_d, fy_d;
  logic [2:0]  lvl_d;
  logic [15:0] score_d, hi_d, time_d;
  logic [15:0] idle_q, idle_d;

  logic [9:0]  lane_cur;
  logic        catch_hit;
  int          dy;
  int          score_sum;

  // Catch window: rod within [fish_x, fish_x+W] and line tip within +/-H of the fish.
  always_comb begin
    lane_cur = lane_of(level);
    dy       = int'(line_y) - int'(fish_y);
    if (dy < 0) dy = -dy;
    catch_hit = up
             && (int'(fish_x) <= int'(rod_x))
             && (int'(rod_x) <= int'(fish_x) + win_w(level))
             && (dy <= win_h(level));
  end

  // NOTE: every next-state variable is given its hold value first, so no path
  // through the case below can leave one unassigned and infer a latch.
  always_comb begin
    st_d      = st_q;
    rod_d     = rod_x;
    line_d    = line_y;
    fx_d      = fish_x;
    fy_d      = fish_y;
    lvl_d     = level;
    score_d   = score;
    hi_d      = hiscore;
    time_d    = time_left;
    idle_d    = idle_q;
    score_sum = int'(score) + int'(level) + 1;

    unique case (st_q)
      ST_FISH: begin
        if (catch_hit) begin
          // Hooking wins over a same-tick timeout; the clock freezes from here.
          st_d   = ST_CATCH;
          fx_d   = rod_x;
          idle_d = '0;
        end else begin
          fy_d = lane_cur;
          fx_d = (int'(fish_x) < X_MIN + FISH_SPEED) ? 10'(X_MAX)
                                                     : 10'(int'(fish_x) - FISH_SPEED);
          line_d = (int'(line_y) + LINE_DROP >= int'(lane_cur)) ? lane_cur
                                                                : 10'(int'(line_y) + LINE_DROP);
          if (right) begin
            if (int'(rod_x) + ROD_SPEED <= X_MAX) rod_d = 10'(int'(rod_x) + ROD_SPEED);
          end else if (left) begin
            if (int'(rod_x) - ROD_SPEED >= ROD_X_MIN) rod_d = 10'(int'(rod_x) - ROD_SPEED);
          end
          if (int'(time_left) <= 1) begin
            time_d = '0;
            st_d   = ST_LOSE;
            hi_d   = max16(hiscore, score);
          end else begin
            time_d = time_left - 16'd1;
          end
        end
      end

      ST_CATCH: begin
        fx_d = rod_x;
        if (int'(fish_y) < SURFACE_Y) begin
          score_d = (score_sum > 16'hFFFF) ? 16'hFFFF : 16'(score_sum);
          idle_d  = '0;
          if (int'(level) == NUM_LEVELS - 1) begin
            st_d = ST_WIN;
            hi_d = max16(hiscore, score_d);
          end else begin
            lvl_d  = level + 3'd1;
            st_d   = ST_FISH;
            fx_d   = 10'(X_MAX);
            fy_d   = lane_of(level + 3'd1);
            time_d = 16'(TIME_LIMIT);
          end
        end else if (reel != '0) begin
          fy_d   = sub_sat(fish_y, REEL_STEP);
          line_d = sub_sat(line_y, REEL_STEP);
          idle_d = '0;
        end else if (int'(idle_q) >= ESCAPE_TICKS - 1) begin
          // Fish escapes and restarts its swim; the line stays where it was.
          st_d   = ST_FISH;
          fx_d   = 10'(X_MAX);
          fy_d   = lane_cur;
          idle_d = '0;
        end else begin
          idle_d = idle_q + 16'd1;
        end
      end

      ST_WIN, ST_LOSE: begin
        if (left || right) begin
          st_d    = ST_FISH;
          lvl_d   = '0;
          score_d = '0;
          line_d  = 10'(LINE_Y_RST);
          fx_d    = 10'(X_MAX);
          fy_d    = 10'(LANE0_Y);
          time_d  = 16'(TIME_LIMIT);
          idle_d  = '0;
        end
      end

      default: st_d = ST_FISH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= ST_FISH;
      rod_x     <= 10'(ROD_X_RST);
      line_y    <= 10'(LINE_Y_RST);
      fish_x    <= 10'(X_MAX);
      fish_y    <= 10'(LANE0_Y);
      level     <= '0;
      score     <= '0;
      hiscore   <= '0;
      time_left <= 16'(TIME_LIMIT);
      idle_q    <= '0;
    end else if (tick) begin
      st_q      <= st_d;
      rod_x     <= rod_d;
      line_y    <= line_d;
      fish_x    <= fx_d;
      fish_y    <= fy_d;
      level     <= lvl_d;
      score     <= score_d;
      hiscore   <= hi_d;
      time_left <= time_d;
      idle_q    <= idle_d;
    end
  end

  assign state = st_q;
  assign win   = (st_q == ST_WIN);
  assign lose  = (st_q == ST_LOSE);

endmodule

// File: tb/tb_fishing_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fishing_game_ctrl
//
// Scoreboard bench for fishing_game_ctrl. Expected output values are pushed
// onto a queue as stimulus is applied and popped and compared once the DUT
// has taken the corresponding ticks.
// -----------------------------------------------------------------------------
module tb_fishing_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        up;
  logic        left;
  logic        right;
  logic [8:0]  reel;
  logic [9:0]  rod_x, line_y, fish_x, fish_y;
  logic [2:0]  level;
  logic [1:0]  state;
  logic [15:0] score, hiscore, time_left;
  logic        win, lose;

  fishing_game_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .up        (up),
    .left      (left),
    .right     (right),
    .reel      (reel),
    .rod_x     (rod_x),
    .line_y    (line_y),
    .fish_x    (fish_x),
    .fish_y    (fish_y),
    .level     (level),
    .state     (state),
    .score     (score),
    .hiscore   (hiscore),
    .time_left (time_left),
    .win       (win),
    .lose      (lose)
  );

  always #5 clk = ~clk;

  typedef enum int {S_ROD, S_LINE, S_FX, S_FY, S_LVL, S_ST, S_SCORE, S_HI, S_TIME, S_WIN, S_LOSE} sig_e;

  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam int FISH = 0, CATCH = 1, WIN = 2, LOSE = 3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_ROD:   return 32'(rod_x);
      S_LINE:  return 32'(line_y);
      S_FX:    return 32'(fish_x);
      S_FY:    return 32'(fish_y);
      S_LVL:   return 32'(level);
      S_ST:    return 32'(state);
      S_SCORE: return 32'(score);
      S_HI:    return 32'(hiscore);
      S_TIME:  return 32'(time_left);
      S_WIN:   return 32'(win);
      default: return 32'(lose);
    endcase
  endfunction

  task automatic push_exp(input string tag, input sig_e s, input int v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = 32'(v);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, observe(e.sig), e.val);
    end
  endtask

  // One tick cycle followed by one idle cycle, so tick=0 cycles are always exercised.
  task automatic step(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Swim to the rod at x=450, hook, reel to the surface and land.
  task automatic catch_level(input int l, input int lane, input int t0, input int n_reel,
                             input int score_exp, input int next_lane, input bit last);
    step(174);
    push_exp($sformatf("L%0d_fx_at_rod", l), S_FX, 450);
    push_exp($sformatf("L%0d_line_sat", l), S_LINE, lane);
    push_exp($sformatf("L%0d_fy_lane", l), S_FY, lane);
    push_exp($sformatf("L%0d_time", l), S_TIME, t0 - 174);
    drain();
    up = 1'b1; step(1); up = 1'b0;
    push_exp($sformatf("L%0d_hooked", l), S_ST, CATCH);
    drain();
    reel = 9'd1; step(n_reel);
    push_exp($sformatf("L%0d_fy_reeled", l), S_FY, 104);
    push_exp($sformatf("L%0d_line_reeled", l), S_LINE, 104);
    push_exp($sformatf("L%0d_still_catch", l), S_ST, CATCH);
    push_exp($sformatf("L%0d_time_frozen", l), S_TIME, t0 - 174);
    drain();
    step(1); reel = 9'd0;
    if (!last) begin
      push_exp($sformatf("L%0d_land_st", l), S_ST, FISH);
      push_exp($sformatf("L%0d_land_lvl", l), S_LVL, l + 1);
      push_exp($sformatf("L%0d_land_fx", l), S_FX, 798);
      push_exp($sformatf("L%0d_land_fy", l), S_FY, next_lane);
      push_exp($sformatf("L%0d_land_time", l), S_TIME, 600);
    end else begin
      push_exp("win_st", S_ST, WIN);
      push_exp("win_flag", S_WIN, 1);
      push_exp("win_hi", S_HI, score_exp);
    end
    push_exp($sformatf("L%0d_land_score", l), S_SCORE, score_exp);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; tick = 1'b0; up = 1'b0; left = 1'b0; right = 1'b0; reel = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset dominates even with tick and buttons active.
    tick = 1'b1; right = 1'b1; reel = 9'd5;
    @(posedge clk); #1;
    push_exp("rst_rod", S_ROD, 450);
    push_exp("rst_line", S_LINE, 155);
    push_exp("rst_fx", S_FX, 798);
    push_exp("rst_fy", S_FY, 470);
    push_exp("rst_lvl", S_LVL, 0);
    push_exp("rst_st", S_ST, FISH);
    push_exp("rst_score", S_SCORE, 0);
    push_exp("rst_hi", S_HI, 0);
    push_exp("rst_time", S_TIME, 600);
    push_exp("rst_win", S_WIN, 0);
    push_exp("rst_lose", S_LOSE, 0);
    drain();
    tick = 1'b0; right = 1'b0; reel = '0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Cycles without tick change nothing, whatever the buttons do.
    right = 1'b1; left = 1'b1; up = 1'b1; reel = 9'd7;
    repeat (3) @(posedge clk);
    #1;
    push_exp("notick_fx", S_FX, 798);
    push_exp("notick_rod", S_ROD, 450);
    push_exp("notick_line", S_LINE, 155);
    push_exp("notick_time", S_TIME, 600);
    drain();
    right = 1'b0; left = 1'b0; up = 1'b0; reel = '0;

    // Free swim: fish walks left, line drops and saturates at the lane.
    step(1);
    push_exp("swim1_fx", S_FX, 796);
    push_exp("swim1_line", S_LINE, 159);
    push_exp("swim1_time", S_TIME, 599);
    drain();
    step(77);
    push_exp("swim78_line", S_LINE, 467);
    drain();
    step(1);
    push_exp("swim79_line_sat", S_LINE, 470);
    drain();
    step(248);
    push_exp("swim327_fx", S_FX, 144);
    push_exp("swim327_line", S_LINE, 470);
    push_exp("swim327_time", S_TIME, 273);
    drain();
    step(1);
    push_exp("swim328_wrap", S_FX, 798);
    push_exp("swim328_time", S_TIME, 272);
    drain();

    // Timeout.
    step(271);
    push_exp("t599_time", S_TIME, 1);
    push_exp("t599_st", S_ST, FISH);
    drain();
    step(1);
    push_exp("timeout_st", S_ST, LOSE);
    push_exp("timeout_lose", S_LOSE, 1);
    push_exp("timeout_hi", S_HI, 0);
    push_exp("timeout_time", S_TIME, 0);
    push_exp("timeout_fx", S_FX, 254);
    drain();
    step(3);
    push_exp("lose_hold_fx", S_FX, 254);
    push_exp("lose_hold_st", S_ST, LOSE);
    drain();
    right = 1'b1; step(1); right = 1'b0;
    push_exp("restart1_st", S_ST, FISH);
    push_exp("restart1_lvl", S_LVL, 0);
    push_exp("restart1_time", S_TIME, 600);
    push_exp("restart1_line", S_LINE, 155);
    push_exp("restart1_fx", S_FX, 798);
    push_exp("restart1_rod", S_ROD, 450);
    push_exp("restart1_lose", S_LOSE, 0);
    drain();

    // Hook at level 0, let it idle and escape.
    step(174);
    push_exp("esc_pre_fx", S_FX, 450);
    push_exp("esc_pre_time", S_TIME, 426);
    drain();
    up = 1'b1; step(1); up = 1'b0;
    push_exp("esc_hook_st", S_ST, CATCH);
    push_exp("esc_hook_fx", S_FX, 450);
    drain();
    step(31);
    push_exp("idle31_st", S_ST, CATCH);
    drain();
    reel = 9'd1; step(1); reel = '0;
    push_exp("reel1_st", S_ST, CATCH);
    push_exp("reel1_fy", S_FY, 468);
    push_exp("reel1_line", S_LINE, 468);
    drain();
    step(31);
    push_exp("idle31b_st", S_ST, CATCH);
    drain();
    step(1);
    push_exp("escape_st", S_ST, FISH);
    push_exp("escape_lvl", S_LVL, 0);
    push_exp("escape_fx", S_FX, 798);
    push_exp("escape_fy", S_FY, 470);
    push_exp("escape_line", S_LINE, 468);
    push_exp("escape_time", S_TIME, 426);
    drain();

    // Land all four levels.
    catch_level(0, 470, 426, 183, 1, 380, 1'b0);
    catch_level(1, 380, 600, 138, 3, 290, 1'b0);
    catch_level(2, 290, 600, 93, 6, 200, 1'b0);
    catch_level(3, 200, 600, 48, 10, 0, 1'b1);
    step(2);
    push_exp("win_hold_st", S_ST, WIN);
    push_exp("win_hold_score", S_SCORE, 10);
    drain();
    right = 1'b1; step(1); right = 1'b0;
    push_exp("restart2_st", S_ST, FISH);
    push_exp("restart2_score", S_SCORE, 0);
    push_exp("restart2_hi", S_HI, 10);
    push_exp("restart2_win", S_WIN, 0);
    push_exp("restart2_fy", S_FY, 470);
    drain();

    // Shift the fish phase with an escape, then hook with time_left=1.
    step(174);
    up = 1'b1; step(1); up = 1'b0;
    step(32);
    push_exp("phase_esc_fx", S_FX, 798);
    push_exp("phase_esc_time", S_TIME, 426);
    drain();
    right = 1'b1; step(52); right = 1'b0;
    push_exp("rod_right52", S_ROD, 606);
    drain();
    step(373);
    push_exp("last_fx", S_FX, 604);
    push_exp("last_time", S_TIME, 1);
    push_exp("last_st", S_ST, FISH);
    drain();
    up = 1'b1; step(1); up = 1'b0;
    push_exp("lastcatch_st", S_ST, CATCH);
    push_exp("lastcatch_lose", S_LOSE, 0);
    push_exp("lastcatch_time", S_TIME, 1);
    push_exp("lastcatch_fx", S_FX, 606);
    drain();
    step(32);
    push_exp("lastesc_time", S_TIME, 1);
    drain();
    step(1);
    push_exp("lose2_st", S_ST, LOSE);
    push_exp("lose2_hi", S_HI, 10);
    drain();

    // Rod saturates at the right edge.
    right = 1'b1; step(1);
    push_exp("restart3_rod", S_ROD, 606);
    push_exp("restart3_time", S_TIME, 600);
    drain();
    step(200);
    push_exp("rod_sat", S_ROD, 798);
    push_exp("rod_sat_fx", S_FX, 398);
    drain();
    step(128);
    push_exp("edge_fx", S_FX, 798);
    push_exp("edge_time", S_TIME, 272);
    drain();
    up = 1'b1; step(1); up = 1'b0;
    push_exp("edge_catch_st", S_ST, CATCH);
    drain();
    reel = 9'd1; step(5);
    push_exp("frozen_rod", S_ROD, 798);
    push_exp("edge_reel_fy", S_FY, 460);
    drain();

    // Asynchronous reset in the middle of a catch.
    rst = 1'b0; #1;
    push_exp("midrst_st", S_ST, FISH);
    push_exp("midrst_score", S_SCORE, 0);
    push_exp("midrst_hi", S_HI, 0);
    push_exp("midrst_rod", S_ROD, 450);
    push_exp("midrst_fy", S_FY, 470);
    push_exp("midrst_time", S_TIME, 600);
    drain();
    right = 1'b0; reel = '0;
    @(posedge clk); #1;
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
